uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Standalone UART transmitter that serializes one byte per request into an 8-bit start/data/optional-parity/stop frame at a fixed baud rate. It is the transmit counterpart of the UART receive path: the receiver's shift register and parity check are built to accept exactly the frames this block emits. It sits behind the UART register decode. The decode pulses a start request with the byte and parity selection, and this block drives the `tx` pin.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bits/s
- `BIT_TICKS`, CLK_FREQ/BAUD (434 at defaults), clock cycles per bit; integer division, must be ≥ 2
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  reset; **synchronous, active-low**
- `tx_send`  in  1  start request; sampled only in IDLE
- `tx_data`  in  8  byte to send; sampled with `tx_send`
- `parity_sel`  in  1  1 = insert even-parity bit after data; sampled with `tx_send`
- `tx`  out  1  serial line, registered, idle high
- `tx_busy`  out  1  high from the cycle after acceptance until return to IDLE
- `tx_done`  out  1  one-cycle pulse when the stop bit completes

## Operation
- States:
  - IDLE: `tx`=1, `tx_busy`=0.
  - START: `tx`=0.
  - DATA: `tx`=`shreg[0]`, sent LSB first.
  - PARITY: `tx`=XOR of the latched byte (even parity).
  - STOP: `tx`=1.
- Transitions:
  - IDLE→START when `tx_send`=1.
  - START→DATA after BIT_TICKS cycles.
  - DATA→DATA for bits 0..6. After bit 7, DATA→PARITY if the latched `parity_sel`=1, otherwise DATA→STOP.
  - PARITY→STOP after BIT_TICKS cycles.
  - STOP→IDLE after BIT_TICKS cycles.
- Acceptance latches `tx_data` into `shreg[7:0]`, `parity_sel` into `par_en`, and the parity bit into `par_bit`. Inputs may change freely after acceptance.
- Bit counter: 3 bits, counts 0..7 in DATA. `shreg` shifts right by one at each DATA bit boundary.
- Baud counter: `$clog2(BIT_TICKS)` bits. Cleared on acceptance and at each bit boundary. Bit boundary when count = BIT_TICKS-1. No wrap past BIT_TICKS-1.
- `tx_send` while busy is ignored: no queueing and no error flag. The requester must wait for `tx_done` or for `tx_busy`=0.
- `tx_send` held high continuously produces back-to-back frames with exactly one idle cycle between the stop bit and the next start bit.
- Reset (`rst`=0 at a rising edge), including mid-frame, produces on the next edge:
  - state = IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0
  - all counters = 0, `shreg`=0
- A partially sent frame is abandoned and the line returns high immediately.

## Timing
- `tx_send` sampled high at edge k: at edge k+1 `tx` falls to 0 and `tx_busy` rises.
- Each bit holds for exactly BIT_TICKS cycles. Start falls at k+1, data bit n begins at k+1+(n+1)·BIT_TICKS.
- Frame length is F = (10 + par_en)·BIT_TICKS cycles. The stop bit ends at edge k+1+F.
- At that same edge `tx_done`=1 for one cycle, `tx_busy`=0, and the state is IDLE.
- A `tx_send` sampled at the `tx_done` edge is accepted. The next start bit then begins one cycle later.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP)
  - function `bit_ticks(clk_freq, baud)`
  - frame constants `UART_DATA_BITS`=8 and `UART_STOP_LEVEL`=1, shared with the receiver
- One sub-module: `uart_baud_cnt`.
  - Ports: `clk`, `rst`, `clear`, `tick`. `tick` pulses when the count reaches BIT_TICKS-1.
  - Parameterised by BIT_TICKS.
  - Reusable by the receiver with a half-bit preload.

## Test plan
All scenarios use CLK_FREQ=1000 and BAUD=100, so BIT_TICKS=10. The bench samples `tx` mid-bit.
1. **Basic frame, no parity.** After reset, pulse `tx_send` with `tx_data`=0xA5 and `parity_sel`=0 → `tx` reads 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles. `tx_done` pulses at cycle 101 after acceptance.
2. **Parity frame.** `tx_data`=0x07, `parity_sel`=1 → after the data, parity bit = 1 and then stop. Frame is 110 cycles. The receiver model reports byte 0x07 with no parity error.
3. **Busy rejection.** Send 0x3C, then pulse `tx_send` with 0xFF at cycle 40 → the line carries only 0x3C and `tx_done` pulses exactly once.
4. **Back-to-back.** Hold `tx_send`=1 with 0x55 → consecutive frames separated by exactly one idle-high cycle. `tx_busy` is low for exactly that one cycle.
5. **Reset mid-frame.** Drive `rst`=0 at cycle 35 of a frame → next edge gives `tx`=1, `tx_busy`=0, with no `tx_done`. A new send of 0x81 after reset release produces a correct frame.
6. **Input stability.** Change `tx_data` every cycle after acceptance of 0x96 → transmitted bits match 0x96.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ==========================================================================
// uart_pkg : frame constants, TX state encoding and baud helper for the UART
// Rev 1.0
// ==========================================================================
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_STOP_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  function automatic int bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ==========================================================================
// uart_tx_frame_if : request/status bundle between register decode and TX
// Rev 1.0
// ==========================================================================
interface uart_tx_frame_if;
  import uart_pkg::*;

  logic                      tx_send;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      parity_sel;
  logic                      tx;
  logic                      tx_busy;
  logic                      tx_done;

  modport master (
    output tx_send, tx_data, parity_sel,
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_send, tx_data, parity_sel,
    output tx, tx_busy, tx_done
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ==========================================================================
// uart_baud_cnt : bit-period counter, tick on count BIT_TICKS-1
// Rev 1.0
// ==========================================================================
module uart_baud_cnt #(
  parameter int BIT_TICKS = 434,
  parameter int PRELOAD   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int             C_CW      = $clog2(BIT_TICKS);
  localparam logic [C_CW-1:0] C_LAST    = C_CW'(BIT_TICKS - 1);
  localparam logic [C_CW-1:0] C_PRELOAD = C_CW'(PRELOAD);

  logic [C_CW-1:0] r_cnt;
  logic            w_tick;

  assign w_tick = (r_cnt == C_LAST);
  assign tick   = w_tick;

  // A receiver sets PRELOAD to half a bit so its ticks land mid-bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= C_PRELOAD;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ==========================================================================
// uart_tx_frame : serialises one byte per request, start/data/parity/stop
// Rev 1.0
// ==========================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int BIT_TICKS = bit_ticks(CLK_FREQ, BAUD)
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave bus
);

  localparam int                C_BIT_CW   = $clog2(UART_DATA_BITS);
  localparam logic [C_BIT_CW-1:0] C_LAST_BIT = C_BIT_CW'(UART_DATA_BITS - 1);

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_state_nxt;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [UART_DATA_BITS-1:0] w_shreg_nxt;
  logic [C_BIT_CW-1:0]       r_bit_cnt;
  logic [C_BIT_CW-1:0]       w_bit_cnt_nxt;
  logic                      r_par_en;
  logic                      w_par_en_nxt;
  logic                      r_par_bit;
  logic                      w_par_bit_nxt;
  logic                      r_tx;
  logic                      w_tx_nxt;
  logic                      r_busy;
  logic                      w_busy_nxt;
  logic                      r_done;
  logic                      w_done_nxt;
  logic                      w_clear;
  logic                      w_tick;

  uart_baud_cnt #(
    .BIT_TICKS (BIT_TICKS),
    .PRELOAD   (0)
  ) u_baud_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par_en  <= w_par_en_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Outputs are registered from the current state, so the line lags the
  // state register by one cycle; done fires on the first IDLE-registered edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_en_nxt  = r_par_en;
    w_par_bit_nxt = r_par_bit;
    w_tx_nxt      = 1'b1;
    w_busy_nxt    = (r_state != IDLE);
    w_done_nxt    = (r_state == IDLE) && r_busy;
    w_clear       = 1'b0;

    case (r_state)
      IDLE: begin
        w_clear  = 1'b1;
        w_tx_nxt = 1'b1;
        if (bus.tx_send) begin
          w_state_nxt   = START;
          w_shreg_nxt   = bus.tx_data;
          w_par_en_nxt  = bus.parity_sel;
          w_par_bit_nxt = ^bus.tx_data;
          w_bit_cnt_nxt = '0;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_tick) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_tx_nxt = r_shreg[0];
        if (w_tick) begin
          w_shreg_nxt   = {1'b0, r_shreg[UART_DATA_BITS-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + C_BIT_CW'(1);
          if (r_bit_cnt == C_LAST_BIT) begin
            w_state_nxt = r_par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        w_tx_nxt = r_par_bit;
        if (w_tick) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        w_tx_nxt = UART_STOP_LEVEL;
        if (w_tick) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ==========================================================================
// tb_uart_tx_frame : directed bench for uart_tx_frame at BIT_TICKS = 10
// Rev 1.0
// ==========================================================================
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;
  int   errors   = 0;
  int   checks   = 0;

  logic log_tx   [0:4095];
  logic log_busy [0:4095];
  logic log_done [0:4095];

  uart_tx_frame_if bus_if ();

  uart_tx_frame #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // log[e] holds the outputs as they stand after rising edge number e
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk) begin
    log_tx[edge_cnt]   <= bus_if.tx;
    log_busy[edge_cnt] <= bus_if.tx_busy;
    log_done[edge_cnt] <= bus_if.tx_done;
  end

  function automatic logic frame_bit(input logic [7:0] d, input logic p, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9 && p) return ^d;
    return 1'b1;
  endfunction

  task automatic wait_to(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic p, output int acc);
    bus_if.tx_data    = d;
    bus_if.parity_sel = p;
    bus_if.tx_send    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.tx_send = 1'b0;
    acc = edge_cnt;
  endtask

  task automatic test_reset;
    rst               = 1'b0;
    bus_if.tx_send    = 1'b0;
    bus_if.tx_data    = 8'h00;
    bus_if.parity_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_if.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus_if.tx); end
    checks++; if (bus_if.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.tx_busy); end
    checks++; if (bus_if.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus_if.tx_done); end
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus_if.tx !== 1'b1) begin errors++; $display("FAIL idle_tx: got %b want 1", bus_if.tx); end
    checks++; if (bus_if.tx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus_if.tx_busy); end
  endtask

  task automatic test_basic;
    int acc;
    send(8'hA5, 1'b0, acc);
    wait_to(acc + 103);
    checks++; if (log_tx[acc] !== 1'b1) begin errors++; $display("FAIL basic_accept_tx: got %b want 1", log_tx[acc]); end
    checks++; if (log_busy[acc] !== 1'b0) begin errors++; $display("FAIL basic_accept_busy: got %b want 0", log_busy[acc]); end
    checks++; if (log_tx[acc+1] !== 1'b0) begin errors++; $display("FAIL basic_start_edge: got %b want 0", log_tx[acc+1]); end
    checks++; if (log_busy[acc+1] !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", log_busy[acc+1]); end
    checks++; if (log_tx[acc+10] !== 1'b0) begin errors++; $display("FAIL basic_start_last: got %b want 0", log_tx[acc+10]); end
    checks++; if (log_tx[acc+11] !== 1'b1) begin errors++; $display("FAIL basic_bit0_first: got %b want 1", log_tx[acc+11]); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_tx[acc+6+10*i] !== frame_bit(8'hA5, 1'b0, i)) begin
        errors++; $display("FAIL basic_bit%0d: got %b want %b", i, log_tx[acc+6+10*i], frame_bit(8'hA5, 1'b0, i));
      end
    end
    checks++; if (log_done[acc+100] !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b want 0", log_done[acc+100]); end
    checks++; if (log_done[acc+101] !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", log_done[acc+101]); end
    checks++; if (log_busy[acc+101] !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", log_busy[acc+101]); end
    checks++; if (log_done[acc+102] !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", log_done[acc+102]); end
  endtask

  task automatic test_parity;
    int         acc;
    logic [7:0] rx_byte;
    logic       rx_par;
    send(8'h07, 1'b1, acc);
    wait_to(acc + 113);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (log_tx[acc+6+10*i] !== frame_bit(8'h07, 1'b1, i)) begin
        errors++; $display("FAIL parity_bit%0d: got %b want %b", i, log_tx[acc+6+10*i], frame_bit(8'h07, 1'b1, i));
      end
    end
    for (int i = 0; i < 8; i++) rx_byte[i] = log_tx[acc+16+10*i];
    rx_par = log_tx[acc+96];
    checks++; if (rx_byte !== 8'h07) begin errors++; $display("FAIL parity_rx_byte: got %h want 07", rx_byte); end
    checks++; if ((^rx_byte ^ rx_par) !== 1'b0) begin errors++; $display("FAIL parity_rx_check: parity bit %b for byte %h", rx_par, rx_byte); end
    checks++; if (log_done[acc+101] !== 1'b0) begin errors++; $display("FAIL parity_done_early: got %b want 0", log_done[acc+101]); end
    checks++; if (log_busy[acc+110] !== 1'b1) begin errors++; $display("FAIL parity_busy: got %b want 1", log_busy[acc+110]); end
    checks++; if (log_done[acc+111] !== 1'b1) begin errors++; $display("FAIL parity_done: got %b want 1", log_done[acc+111]); end
  endtask

  task automatic test_busy_reject;
    int acc;
    int ndone;
    send(8'h3C, 1'b0, acc);
    wait_to(acc + 39);
    bus_if.tx_data = 8'hFF;
    bus_if.tx_send = 1'b1;
    @(posedge clk);
    #1;
    bus_if.tx_send = 1'b0;
    wait_to(acc + 135);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_tx[acc+6+10*i] !== frame_bit(8'h3C, 1'b0, i)) begin
        errors++; $display("FAIL reject_bit%0d: got %b want %b", i, log_tx[acc+6+10*i], frame_bit(8'h3C, 1'b0, i));
      end
    end
    ndone = 0;
    for (int e = acc; e <= acc + 135; e++) if (log_done[e] === 1'b1) ndone++;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL reject_done_count: got %0d want 1", ndone); end
    checks++; if (log_tx[acc+120] !== 1'b1) begin errors++; $display("FAIL reject_line_idle: got %b want 1", log_tx[acc+120]); end
    checks++; if (log_busy[acc+120] !== 1'b0) begin errors++; $display("FAIL reject_busy_idle: got %b want 0", log_busy[acc+120]); end
  endtask

  task automatic test_back_to_back;
    int acc;
    int nlow;
    bus_if.tx_data    = 8'h55;
    bus_if.parity_sel = 1'b0;
    bus_if.tx_send    = 1'b1;
    @(posedge clk);
    #1;
    acc = edge_cnt;
    wait_to(acc + 150);
    bus_if.tx_send = 1'b0;
    wait_to(acc + 215);
    checks++; if (log_done[acc+101] !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", log_done[acc+101]); end
    checks++; if (log_tx[acc+101] !== 1'b1) begin errors++; $display("FAIL b2b_gap_tx: got %b want 1", log_tx[acc+101]); end
    checks++; if (log_tx[acc+102] !== 1'b0) begin errors++; $display("FAIL b2b_start2: got %b want 0", log_tx[acc+102]); end
    checks++; if (log_busy[acc+102] !== 1'b1) begin errors++; $display("FAIL b2b_busy2: got %b want 1", log_busy[acc+102]); end
    nlow = 0;
    for (int e = acc + 1; e <= acc + 201; e++) if (log_busy[e] !== 1'b1) nlow++;
    checks++; if (nlow !== 1) begin errors++; $display("FAIL b2b_busy_low_cycles: got %0d want 1", nlow); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_tx[acc+107+10*i] !== frame_bit(8'h55, 1'b0, i)) begin
        errors++; $display("FAIL b2b_frame2_bit%0d: got %b want %b", i, log_tx[acc+107+10*i], frame_bit(8'h55, 1'b0, i));
      end
    end
    checks++; if (log_done[acc+202] !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", log_done[acc+202]); end
    checks++; if (log_busy[acc+210] !== 1'b0) begin errors++; $display("FAIL b2b_no_third: got %b want 0", log_busy[acc+210]); end
  endtask

  task automatic test_reset_mid;
    int acc;
    int acc2;
    int ndone;
    send(8'hF0, 1'b0, acc);
    wait_to(acc + 34);
    checks++; if (log_tx[acc+34] !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx: got %b want 0", log_tx[acc+34]); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus_if.tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", bus_if.tx); end
    checks++; if (bus_if.tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus_if.tx_busy); end
    checks++; if (bus_if.tx_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", bus_if.tx_done); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_to(acc + 140);
    ndone = 0;
    for (int e = acc + 35; e <= acc + 140; e++) if (log_done[e] === 1'b1) ndone++;
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", ndone); end
    checks++; if (log_tx[acc+120] !== 1'b1) begin errors++; $display("FAIL rstmid_line_high: got %b want 1", log_tx[acc+120]); end
    send(8'h81, 1'b0, acc2);
    wait_to(acc2 + 103);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_tx[acc2+6+10*i] !== frame_bit(8'h81, 1'b0, i)) begin
        errors++; $display("FAIL rstmid_new_bit%0d: got %b want %b", i, log_tx[acc2+6+10*i], frame_bit(8'h81, 1'b0, i));
      end
    end
    checks++; if (log_done[acc2+101] !== 1'b1) begin errors++; $display("FAIL rstmid_new_done: got %b want 1", log_done[acc2+101]); end
  endtask

  task automatic test_input_stability;
    int acc;
    send(8'h96, 1'b0, acc);
    repeat (105) begin
      bus_if.tx_data    = 8'($urandom);
      bus_if.parity_sel = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus_if.tx_data    = 8'h00;
    bus_if.parity_sel = 1'b0;
    wait_to(acc + 108);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_tx[acc+6+10*i] !== frame_bit(8'h96, 1'b0, i)) begin
        errors++; $display("FAIL stable_bit%0d: got %b want %b", i, log_tx[acc+6+10*i], frame_bit(8'h96, 1'b0, i));
      end
    end
    checks++; if (log_done[acc+101] !== 1'b1) begin errors++; $display("FAIL stable_done: got %b want 1", log_done[acc+101]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    test_input_stability();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
